// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: accepts a parallel byte and serialises start, data (LSB first),
// optional parity and stop bits on tx_out, one bit per clock, with registered busy/frame_done.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  D_valid,
  input  logic                  par_en,
  input  logic                  par_bit,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_s;
  logic                  par_en_r;
  logic                  par_en_s;
  logic                  tx_s;
  logic                  busy_s;
  logic                  done_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; the line idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r    <= '0;
      cnt_r      <= '0;
      par_en_r   <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      shift_r    <= shift_s;
      cnt_r      <= cnt_s;
      par_en_r   <= par_en_s;
      tx_out     <= tx_s;
      busy       <= busy_s;
      frame_done <= done_s;
    end
  end

  // Next-state and next-output logic; each branch computes the value tx_out shows next cycle.
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    cnt_s    = cnt_r;
    par_en_s = par_en_r;
    tx_s     = tx_out;
    busy_s   = busy;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        if (D_valid) begin
          shift_s  = p_data;
          par_en_s = par_en;
          cnt_s    = '0;
          busy_s   = 1'b1;
          tx_s     = 1'b0;
          state_s  = START;
        end else begin
          state_s  = IDLE;
        end
      end
      START: begin
        tx_s    = shift_r[0];
        shift_s = shift_r >> 1;
        state_s = DATA;
      end
      DATA: begin
        // Counter holds at the last bit index; it is only cleared on the next accept.
        if (cnt_r == CNT_LAST) begin
          if (par_en_r) begin
            tx_s    = par_bit;
            state_s = PARITY;
          end else begin
            tx_s    = 1'b1;
            state_s = STOP;
          end
        end else begin
          tx_s    = shift_r[0];
          shift_s = shift_r >> 1;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      PARITY: begin
        tx_s    = 1'b1;
        state_s = STOP;
      end
      STOP: begin
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        tx_s    = 1'b1;
        busy_s  = 1'b0;
        cnt_s   = '0;
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl: reset, plain and parity frames, busy gating,
// back-to-back frames and mid-frame reset, checked cycle by cycle against hand-built frames.
module tb_uart_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] p_data;
  logic       D_valid;
  logic       par_en;
  logic       par_bit;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .p_data     (p_data),
    .D_valid    (D_valid),
    .par_en     (par_en),
    .par_bit    (par_bit),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic tx, input logic bz, input logic fd);
    check({tag, ".tx_out"}, tx_out, tx);
    check({tag, ".busy"}, busy, bz);
    check({tag, ".frame_done"}, frame_done, fd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a payload and pass the accept edge; D_valid is left high for the caller.
  task automatic accept(input logic [7:0] d, input logic pe, input logic pb);
    D_valid = 1'b1;
    p_data  = d;
    par_en  = pe;
    par_bit = pb;
    step();
  endtask

  // Starting in the START cycle, check every frame cycle and the frame_done cycle.
  // inj >= 0 pulses a competing D_valid with 8'hFF and flipped par_en in that frame cycle.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pb, input int inj);
    logic [10:0] fb;
    int          n;
    fb    = 11'h7FF;
    fb[0] = 1'b0;
    for (int k = 0; k < 8; k++) fb[1+k] = d[k];
    if (pe) begin
      fb[9] = pb;
      n     = 11;
    end else begin
      n     = 10;
    end
    for (int i = 0; i < n; i++) begin
      if (inj >= 0 && i == inj) begin
        D_valid = 1'b1;
        p_data  = 8'hFF;
        par_en  = ~pe;
      end else if (inj >= 0 && i == inj + 1) begin
        D_valid = 1'b0;
        p_data  = d;
        par_en  = pe;
      end
      check_outs($sformatf("%s.bit%0d", tag, i), fb[i], 1'b1, 1'b0);
      step();
    end
    check_outs({tag, ".done"}, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    D_valid = 1'b1;
    p_data  = 8'hA5;
    par_en  = 1'b0;
    par_bit = 1'b0;
    #1;
    check_outs("reset.t0", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("reset.c%0d", i), 1'b1, 1'b0, 1'b0);
    end
    D_valid = 1'b0;
    reset   = 1'b0;
    step();
    check_outs("reset.idle", 1'b1, 1'b0, 1'b0);

    // No parity, 8'hA5: 0,1,0,1,0,0,1,0,1,1
    accept(8'hA5, 1'b0, 1'b0);
    D_valid = 1'b0;
    check_frame("nopar_a5", 8'hA5, 1'b0, 1'b0, -1);
    step();
    check_outs("nopar_a5.after", 1'b1, 1'b0, 1'b0);

    // Even parity of 8'h03 is 0: 0,1,1,0,0,0,0,0,0,0,1
    accept(8'h03, 1'b1, 1'b0);
    D_valid = 1'b0;
    check_frame("even_03", 8'h03, 1'b1, 1'b0, -1);
    step();

    // Odd parity of 8'h07 is 0
    accept(8'h07, 1'b1, 1'b0);
    D_valid = 1'b0;
    check_frame("odd_07", 8'h07, 1'b1, 1'b0, -1);
    step();

    // Parity slot carrying a 1 with a zero-heavy payload
    accept(8'h80, 1'b1, 1'b1);
    D_valid = 1'b0;
    check_frame("par1_80", 8'h80, 1'b1, 1'b1, -1);
    step();

    // Busy gating: 8'hFF request in frame cycle 4 is ignored
    accept(8'h3C, 1'b0, 1'b0);
    D_valid = 1'b0;
    check_frame("gate_3c", 8'h3C, 1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("gate.idle%0d", i), 1'b1, 1'b0, 1'b0);
    end

    // Back-to-back with D_valid held: exactly one idle cycle between frames
    accept(8'h55, 1'b0, 1'b0);
    p_data = 8'hAA;
    check_frame("b2b_55", 8'h55, 1'b0, 1'b0, -1);
    step();
    D_valid = 1'b0;
    check_frame("b2b_aa", 8'hAA, 1'b0, 1'b0, -1);
    step();
    check_outs("b2b.after", 1'b1, 1'b0, 1'b0);

    // Mid-frame reset during data bit 3
    accept(8'hA5, 1'b0, 1'b0);
    D_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("midrst.pre_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_outs("midrst.async", 1'b1, 1'b0, 1'b0);
    step();
    check_outs("midrst.held", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_outs("midrst.idle", 1'b1, 1'b0, 1'b0);
    accept(8'h96, 1'b1, 1'b1);
    D_valid = 1'b0;
    check_frame("post_rst_96", 8'h96, 1'b1, 1'b1, -1);
    step();
    check_outs("post_rst.after", 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
